// File: rtl/program_counter_pkg.sv
// Shared CPU definitions used by the program counter and next-PC logic.
//   ADDR_W       : instruction address width
//   addr_t       : instruction address type
//   PC_RESET_VEC : address held at power-up and forced by reset
//   INSTR_BYTES  : size of one instruction, the sequential PC step
package program_counter_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t       PC_RESET_VEC = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES  = 4;

endpackage : program_counter_pkg

// File: rtl/pc_incr.sv
// Constant adder: y = a + INC, modulo 2^WIDTH (carry discarded).
// Used for PC+4 and reusable by branch-target logic.
//   a : operand address
//   y : a + INC
module pc_incr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INC   = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a + WIDTH'(INC);
  end

endmodule : pc_incr

// File: rtl/program_counter.sv
// Program-counter register for the single-cycle MIPS datapath.
// Loads the next-PC value every rising clock edge; no enable or stall.
// Optional feature macro: PC_ALIGN_CHECK_EN adds the registered
// `misaligned` flag (set when a loaded pcin has pcin[1:0] != 0).
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low; forces pcout to RESET_VAL
//   pcin       : next-PC value from the next-PC mux
//   pcout      : current PC, registered
//   pc_plus4   : pcout + 4, combinational, wraps modulo 2^WIDTH
//   misaligned : (PC_ALIGN_CHECK_EN only) last loaded PC was unaligned
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned       WIDTH     = ADDR_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(PC_RESET_VEC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcin,
  output logic [WIDTH-1:0] pcout,
`ifdef PC_ALIGN_CHECK_EN
  output logic             misaligned,
`endif
  output logic [WIDTH-1:0] pc_plus4
);

  // Declaration initialiser gives the power-up value without needing a
  // reset pulse, so an undriven/X reset before the first edge cannot
  // disturb it.
  logic [WIDTH-1:0] pc_q = RESET_VAL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pcin;
    end
  end

  assign pcout = pc_q;

  pc_incr #(
    .WIDTH (WIDTH),
    .INC   (INSTR_BYTES)
  ) u_pc_incr (
    .a (pc_q),
    .y (pc_plus4)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= (pcin[1:0] != 2'b00);
    end
  end

  assign misaligned = mis_q;
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcin = '0;
  logic [31:0] pcout;
  logic [31:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state: the address the PC should hold, derived from the
  // rule "last pcin seen at a clock edge with reset high, else 0".
  logic [31:0] exp_pc  = 32'h0;
  logic        exp_mis = 1'b0;

  program_counter #(
    .WIDTH     (32),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pcin       (pcin),
    .pcout      (pcout),
`ifdef PC_ALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .pc_plus4   (pc_plus4)
  );

  always #5 clk = ~clk;

  // One clock edge, with the model following the same edge; sample #1 later.
  task automatic edge_and_model();
    @(posedge clk);
    if (reset === 1'b1) begin
      exp_pc  = pcin;
      exp_mis = (pcin % 4) != 0;
    end else begin
      exp_pc  = 32'h0;
      exp_mis = 1'b0;
    end
    #1;
  endtask

  task automatic check_state(input string name);
    n_checks++;
    if (pcout !== exp_pc) begin
      n_fail++;
      $display("FAIL %s pcout: got %h expected %h", name, pcout, exp_pc);
    end
    n_checks++;
    if (pc_plus4 !== exp_pc + 32'd4) begin
      n_fail++;
      $display("FAIL %s pc_plus4: got %h expected %h", name, pc_plus4, exp_pc + 32'd4);
    end
`ifdef PC_ALIGN_CHECK_EN
    n_checks++;
    if (misaligned !== exp_mis) begin
      n_fail++;
      $display("FAIL %s misaligned: got %b expected %b", name, misaligned, exp_mis);
    end
`endif
  endtask

  task automatic test_reset();
    // Before any clock edge and with reset never driven.
    #1;
    n_checks++;
    if (pcout !== 32'h0) begin
      n_fail++;
      $display("FAIL powerup pcout: got %h expected %h", pcout, 32'h0);
    end
    n_checks++;
    if (pc_plus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL powerup pc_plus4: got %h expected %h", pc_plus4, 32'h4);
    end
  endtask

  task automatic test_increment();
    reset = 1'b1;
    pcin  = 32'd4;
    edge_and_model();
    n_checks++;
    if (pcout !== 32'd4) begin
      n_fail++;
      $display("FAIL increment pcout: got %h expected %h", pcout, 32'd4);
    end
    check_state("increment");
  endtask

  task automatic test_jump();
    pcin = 32'd804;
    edge_and_model();
    n_checks++;
    if (pcout !== 32'd804) begin
      n_fail++;
      $display("FAIL jump pcout: got %h expected %h", pcout, 32'd804);
    end
    for (int i = 0; i < 3; i++) begin
      edge_and_model();
      check_state("hold804");
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;   // between edges
    #1;
    n_checks++;
    if (pcout !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset pcout: got %h expected %h", pcout, 32'h0);
    end
    // Clock edge while reset low: reset has priority.
    pcin = 32'h0000_1234;
    edge_and_model();
    check_state("reset_priority");
    // Release mid-cycle, next edge loads pcin.
    #2;
    reset = 1'b1;
    pcin  = 32'h0000_0040;
    #1;
    check_state("released_before_edge");
    edge_and_model();
    n_checks++;
    if (pcout !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL release_load pcout: got %h expected %h", pcout, 32'h40);
    end
  endtask

  task automatic test_wrap();
    pcin = 32'hFFFF_FFFC;
    edge_and_model();
    n_checks++;
    if (pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap pc_plus4: got %h expected %h", pc_plus4, 32'h0);
    end
    check_state("wrap");
  endtask

  task automatic test_align();
    pcin = 32'd6;
    edge_and_model();
    n_checks++;
    if (pcout !== 32'd6) begin
      n_fail++;
      $display("FAIL align6 pcout: got %h expected %h", pcout, 32'd6);
    end
`ifdef PC_ALIGN_CHECK_EN
    n_checks++;
    if (misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL align6 misaligned: got %b expected 1", misaligned);
    end
`endif
    pcin = 32'd8;
    edge_and_model();
`ifdef PC_ALIGN_CHECK_EN
    n_checks++;
    if (misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL align8 misaligned: got %b expected 0", misaligned);
    end
`endif
    check_state("align8");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      #2;
      pcin = $urandom;
      if ($urandom_range(0, 3) == 0) pcin[1:0] = 2'b00;
      reset = ($urandom_range(0, 9) != 0);
      #1;
      if (reset == 1'b0) begin
        exp_pc  = 32'h0;
        exp_mis = 1'b0;
        check_state("random_async");
      end
      edge_and_model();
      check_state("random");
    end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      pcin = 32'h1000 + 32'(i) * 32'd4;
      edge_and_model();
      check_state("back_to_back");
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_increment();
    test_jump();
    test_async_reset();
    test_wrap();
    test_align();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_program_counter

// File: doc/program_counter.md
# program_counter

Program-counter register for the single-cycle MIPS datapath. It holds the address of the current instruction and presents it to instruction memory and the next-PC logic. On every rising clock edge it loads the next-PC value computed upstream (PC+4, branch target, jump target or register target). It also provides a precomputed PC+4 for the datapath.

## Interface
Parameters:
- `WIDTH`, default 32: address width in bits.
- `RESET_VAL`, default 32'h0000_0000: value loaded by reset and held at power-up.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. 0 forces `pcout` to `RESET_VAL` immediately.
- `pcin`, input, WIDTH: next-PC value, sampled on each rising `clk` edge.
- `pcout`, output, WIDTH: current PC, registered.
- `pc_plus4`, output, WIDTH: `pcout + 4`, combinational, modulo 2^WIDTH.
- `misaligned`, output, 1: alignment flag. Present only with `PC_ALIGN_CHECK_EN`.

## Operation
- One WIDTH-bit register drives `pcout`.
- While `reset` = 0:
  - The register is `RESET_VAL`.
  - `pcin` is ignored.
  - `misaligned` = 0.
- While `reset` = 1: on each rising `clk` edge the register loads `pcin`. There is no enable or stall, so the PC loads every cycle.
- Power-up / simulation start: the register is initialised to `RESET_VAL` without any reset pulse. `pcout` must read 0 before the first edge and before `reset` is ever driven. An X or Z on `reset` must not corrupt this initial value.
- `pc_plus4`:
  - Computed as `pcout + 4`, WIDTH bits, carry discarded.
  - Wrap-around: 32'hFFFF_FFFC gives 32'h0000_0000.
- `pcin` is loaded verbatim, with no masking of the low bits and no range check.
- Reset mid-operation: the falling edge of `reset` clears `pcout` asynchronously, without waiting for `clk`.
- Reset release: the first rising `clk` edge with `reset` = 1 loads `pcin`.
- Simultaneous events: a rising `clk` edge while `reset` = 0 leaves the register at `RESET_VAL`. Reset has priority.

## Timing
- `pcin` to `pcout` latency: 1 clock. `pcout` changes only at a rising `clk` edge or an asynchronous reset assertion.
- `pcout` to `pc_plus4`: combinational, same cycle.
- `reset` to `pcout`: asynchronous, no clock required.
- `pcin` must be stable for setup and hold around the rising edge. It is a purely combinational feed from the next-PC mux.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - `misaligned` port exists.
  - It is a registered flag, set on the clock edge that loads a `pcin` with `pcin[1:0]` != 0.
  - It clears on the next edge that loads an aligned value, or on reset.
  - `pcout` still loads the unaligned value unchanged.
- `PC_ALIGN_CHECK_EN` undefined: no `misaligned` port and no extra logic. All other behaviour is identical.

## Structure
- The shared CPU package holds:
  - `WIDTH` (`ADDR_W` = 32).
  - `RESET_VAL` (`PC_RESET_VEC` = 0).
  - The constant `INSTR_BYTES` = 4 used by `pc_plus4`.
  - The address typedef `addr_t`.
- The PC+4 increment is a natural sub-module, `pc_incr`: a WIDTH-bit constant adder reusable by branch-target logic.
- The register itself stays in `program_counter`.

## Test plan
- Power-up: no clock edges, `reset` undriven → `pcout` = 0 and `pc_plus4` = 4.
- Increment: `reset` = 1, `pcin` = `pcout` + 4 = 4, one rising edge → `pcout` = 4.
- Large jump: `pcin` = 804, one edge → `pcout` = 804.
- Reset:
  - Drive `reset` = 1 for 3 edges → `pcout` stays 804 (given `pcin` held at 804).
  - Then drive `reset` = 0 between edges → `pcout` = 0 immediately.
  - Release → next edge loads `pcin`.
- Wrap: `pcin` = 32'hFFFF_FFFC, one edge → `pcout` = 32'hFFFF_FFFC and `pc_plus4` = 0.
- With `PC_ALIGN_CHECK_EN`:
  - `pcin` = 6, one edge → `pcout` = 6, `misaligned` = 1.
  - `pcin` = 8, one edge → `misaligned` = 0.
